// File: rtl/mailbox_agent.sv
// Fabric-side initiator for one mailbox controller port: pushes outbound messages and
// notifies the peer, pulls inbound messages and acknowledges them, one bus request at a time.
module mailbox_agent #(
    parameter int         DEPTH      = 4,
    parameter logic [5:0] NOTIFY_VAL = 6'h01,
    parameter logic [5:0] ACK_VAL    = 6'h02,
    parameter int         TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic [32*DEPTH-1:0] tx_data,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                tx_acked,
    output logic                rx_valid,
    output logic [32*DEPTH-1:0] rx_data,
    output logic                err,
    output logic                mbx_write,
    output logic                mbx_read,
    output logic [5:0]          mbx_addr,
    output logic [31:0]         mbx_wdata,
    input  logic                mbx_ready,
    input  logic [31:0]         mbx_rdata,
    input  logic                mbx_msg_present,
    input  logic                mbx_msg_ack
);
    typedef enum logic [2:0] {IDLE, TX_WR, TX_NTF, RX_RD, RX_ACK, RX_WAIT, GAP} state_t;

    localparam logic [1:0] LAST    = 2'(DEPTH - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, after_q;
    logic [1:0]          idx_q;
    logic [7:0]          cnt_q;
    logic [32*DEPTH-1:0] tx_buf_q, rx_q;
    logic                tx_busy_q, tx_done_q, tx_acked_q, rx_valid_q, err_q, ack_q;
    logic                write_q, read_q;
    logic [5:0]          addr_q;
    logic [31:0]         wdata_q;
    logic                timeout_d;

    // Flag the last waiting cycle so the error pulse lands exactly TIMEOUT cycles in.
    assign timeout_d = (cnt_q >= TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            after_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            tx_buf_q   <= '0;
            rx_q       <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_acked_q <= 1'b0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= mbx_msg_ack;
            tx_acked_q <= mbx_msg_ack & ~ack_q;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            if (tx_start && !tx_busy_q) begin
                tx_buf_q  <= tx_data;
                tx_busy_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    cnt_q <= '0;
                    if (mbx_msg_present) begin
                        read_q  <= 1'b1;
                        addr_q  <= 6'h20;
                        state_q <= RX_RD;
                    end else if (tx_busy_q) begin
                        write_q <= 1'b1;
                        addr_q  <= 6'h30;
                        wdata_q <= tx_buf_q[31:0];
                        state_q <= TX_WR;
                    end
                end
                TX_WR, TX_NTF, RX_RD, RX_ACK: begin
                    if (mbx_ready) begin
                        write_q <= 1'b0;
                        read_q  <= 1'b0;
                        state_q <= GAP;
                        case (state_q)
                            TX_WR: begin
                                if (idx_q == LAST) after_q <= TX_NTF;
                                else begin
                                    idx_q   <= idx_q + 2'd1;
                                    after_q <= TX_WR;
                                end
                            end
                            TX_NTF: begin
                                tx_done_q <= 1'b1;
                                tx_busy_q <= 1'b0;
                                after_q   <= IDLE;
                            end
                            RX_RD: begin
                                rx_q[32*int'(idx_q) +: 32] <= mbx_rdata;
                                if (idx_q == LAST) after_q <= RX_ACK;
                                else begin
                                    idx_q   <= idx_q + 2'd1;
                                    after_q <= RX_RD;
                                end
                            end
                            default: begin
                                rx_valid_q <= 1'b1;
                                after_q    <= RX_WAIT;
                            end
                        endcase
                    end else if (timeout_d) begin
                        write_q <= 1'b0;
                        read_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= GAP;
                        after_q <= IDLE;
                        if (state_q == TX_WR || state_q == TX_NTF) tx_busy_q <= 1'b0;
                    end
                end
                RX_WAIT: begin
                    if (!mbx_msg_present) state_q <= IDLE;
                    else if (timeout_d) begin
                        err_q   <= 1'b1;
                        state_q <= GAP;
                        after_q <= IDLE;
                    end
                end
                GAP: begin
                    // Controller ready is stale here; the next request is launched, never completed.
                    state_q <= after_q;
                    cnt_q   <= '0;
                    case (after_q)
                        TX_WR: begin
                            write_q <= 1'b1;
                            addr_q  <= 6'h30 + {2'b00, idx_q, 2'b00};
                            wdata_q <= tx_buf_q[32*int'(idx_q) +: 32];
                        end
                        TX_NTF: begin
                            write_q <= 1'b1;
                            addr_q  <= 6'h04;
                            wdata_q <= {26'd0, NOTIFY_VAL};
                        end
                        RX_RD: begin
                            read_q <= 1'b1;
                            addr_q <= 6'h20 + {2'b00, idx_q, 2'b00};
                        end
                        RX_ACK: begin
                            write_q <= 1'b1;
                            addr_q  <= 6'h04;
                            wdata_q <= {26'd0, ACK_VAL};
                        end
                        default: ;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;
    assign tx_acked  = tx_acked_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_q;
    assign err       = err_q;
    assign mbx_write = write_q;
    assign mbx_read  = read_q;
    assign mbx_addr  = addr_q;
    assign mbx_wdata = wdata_q;
endmodule

// File: tb/tb_mailbox_agent.sv
// Scoreboard bench for mailbox_agent: a controller model answers bus requests, expected
// bus completions and output pulses are queued by the stimulus and popped by a monitor.
module tb_mailbox_agent;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic                clk = 1'b0;
    logic                reset;
    logic                tx_start;
    logic [32*DEPTH-1:0] tx_data;
    logic                tx_busy, tx_done, tx_acked, rx_valid, err;
    logic [32*DEPTH-1:0] rx_data;
    logic                mbx_write, mbx_read;
    logic [5:0]          mbx_addr;
    logic [31:0]         mbx_wdata;
    logic                mbx_ready;
    logic [31:0]         mbx_rdata;
    logic                mbx_msg_present, mbx_msg_ack;

    mailbox_agent #(.DEPTH(DEPTH), .NOTIFY_VAL(6'h01), .ACK_VAL(6'h02), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_acked(tx_acked),
        .rx_valid(rx_valid), .rx_data(rx_data), .err(err),
        .mbx_write(mbx_write), .mbx_read(mbx_read), .mbx_addr(mbx_addr),
        .mbx_wdata(mbx_wdata), .mbx_ready(mbx_ready), .mbx_rdata(mbx_rdata),
        .mbx_msg_present(mbx_msg_present), .mbx_msg_ack(mbx_msg_ack)
    );

    always #5 clk = ~clk;

    typedef struct {logic we; logic [5:0] addr; logic [31:0] data;} bus_t;
    typedef struct {int kind; logic [127:0] data;} ev_t;
    bus_t bq[$];
    ev_t  eq[$];

    int checks = 0;
    int errors = 0;

    // Controller model: registered ready after lat extra cycles, ready stays high one stale cycle.
    int          lat = 0;
    logic        no_ready = 1'b0;
    logic [31:0] rd_base = 32'hA0;
    int          hold = 0;
    always @(posedge clk) begin
        if (mbx_write || mbx_read) hold <= hold + 1;
        else hold <= 0;
        mbx_ready <= (mbx_write || mbx_read) && !no_ready && (hold >= lat);
        mbx_rdata <= rd_base + {28'd0, mbx_addr[5:2] - 4'd8};
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [5:0] a, input logic [31:0] d);
        bus_t b;
        b.we = 1'b1; b.addr = a; b.data = d;
        bq.push_back(b);
    endtask

    task automatic push_r(input logic [5:0] a);
        bus_t b;
        b.we = 1'b0; b.addr = a; b.data = '0;
        bq.push_back(b);
    endtask

    task automatic push_ev(input int k, input logic [127:0] d);
        ev_t e;
        e.kind = k; e.data = d;
        eq.push_back(e);
    endtask

    task automatic ev_check(input int k);
        ev_t e;
        checks++;
        if (eq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse kind=%0d expected=none", k);
        end else begin
            e = eq.pop_front();
            if (e.kind != k || (k == 1 && rx_data !== e.data)) begin
                errors++;
                $display("FAIL pulse actual kind=%0d data=%0h expected kind=%0d data=%0h",
                         k, rx_data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: bus protocol, completions and output pulses.
    initial begin
        logic       p_req, p_cpl, p_we;
        logic [5:0] p_addr;
        logic [31:0] p_wdata;
        bus_t       b;
        p_req = 0; p_cpl = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_req = 0; p_cpl = 0;
            end else begin
                if ((mbx_write || mbx_read) && p_req &&
                    (mbx_addr != p_addr || mbx_wdata != p_wdata || mbx_write != p_we)) begin
                    checks++; errors++;
                    $display("FAIL req_unstable actual addr=%0h expected addr=%0h", mbx_addr, p_addr);
                end
                if ((mbx_write || mbx_read) && p_cpl) begin
                    checks++; errors++;
                    $display("FAIL no_gap actual req=1 expected req=0 addr=%0h", mbx_addr);
                end
                if (mbx_write && mbx_read) begin
                    checks++; errors++;
                    $display("FAIL both_req actual=11 expected one");
                end
                if ((mbx_write || mbx_read) && mbx_ready) begin
                    checks++;
                    if (bq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_bus actual we=%0b addr=%0h expected=none", mbx_write, mbx_addr);
                    end else begin
                        b = bq.pop_front();
                        if (b.we != mbx_write || b.addr != mbx_addr || (b.we && b.data != mbx_wdata)) begin
                            errors++;
                            $display("FAIL bus actual we=%0b addr=%0h data=%0h expected we=%0b addr=%0h data=%0h",
                                     mbx_write, mbx_addr, mbx_wdata, b.we, b.addr, b.data);
                        end
                    end
                end
                if (tx_done)  ev_check(0);
                if (rx_valid) ev_check(1);
                if (err)      ev_check(2);
                if (tx_acked) ev_check(3);
                p_cpl   = (mbx_write || mbx_read) && mbx_ready;
                p_req   = (mbx_write || mbx_read) && !mbx_ready;
                p_we    = mbx_write;
                p_addr  = mbx_addr;
                p_wdata = mbx_wdata;
            end
        end
    end

    task automatic wait_busy_low(input string name, input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin @(negedge clk); n++; end
        if (tx_busy) chk(name, 1, 0);
    endtask

    task automatic wait_eq(input string name, input int left, input int budget);
        int n = 0;
        while (eq.size() > left && n < budget) begin @(negedge clk); n++; end
        if (eq.size() > left) chk(name, eq.size(), left);
    endtask

    initial begin
        int n;
        reset = 1'b1; tx_start = 0; tx_data = '0; mbx_msg_present = 0; mbx_msg_ack = 0;
        repeat (3) @(negedge clk);
        chk("rst_bus", {mbx_write, mbx_read, mbx_addr, mbx_wdata}, 0);
        chk("rst_pulses", {tx_busy, tx_done, tx_acked, rx_valid, err}, 0);
        chk("rst_rxdata", rx_data, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Plain TX with one-cycle ready delay; a second start while busy must be ignored.
        lat = 1;
        push_w(6'h30, 32'h11); push_w(6'h34, 32'h22); push_w(6'h38, 32'h33); push_w(6'h3C, 32'h44);
        push_w(6'h04, 32'h01); push_ev(0, 0);
        tx_data = {32'h44, 32'h33, 32'h22, 32'h11}; tx_start = 1;
        @(negedge clk); tx_start = 0;
        chk("tx_busy_set", tx_busy, 1);
        tx_data = {4{32'hDEAD}}; tx_start = 1;
        @(negedge clk); tx_start = 0;
        wait_busy_low("tx_complete", 200);
        repeat (3) @(negedge clk);
        chk("tx_drained", {bq.size(), eq.size()}, 0);

        // Plain RX; holding msg_present must not trigger a second read.
        lat = 0; rd_base = 32'hA0;
        push_r(6'h20); push_r(6'h24); push_r(6'h28); push_r(6'h2C); push_w(6'h04, 32'h02);
        push_ev(1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        mbx_msg_present = 1;
        wait_eq("rx_complete", 0, 200);
        repeat (20) @(negedge clk);
        chk("rx_no_reread", {mbx_read, mbx_write, 32'(bq.size())}, 0);
        mbx_msg_present = 0;
        repeat (3) @(negedge clk);

        // Simultaneous RX and TX request: RX runs to completion first.
        rd_base = 32'hB0;
        push_r(6'h20); push_r(6'h24); push_r(6'h28); push_r(6'h2C); push_w(6'h04, 32'h02);
        push_ev(1, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        push_w(6'h30, 32'h55); push_w(6'h34, 32'h66); push_w(6'h38, 32'h77); push_w(6'h3C, 32'h88);
        push_w(6'h04, 32'h01); push_ev(0, 0);
        mbx_msg_present = 1; tx_data = {32'h88, 32'h77, 32'h66, 32'h55}; tx_start = 1;
        @(negedge clk); tx_start = 0;
        wait_eq("both_rx_phase", 1, 200);
        mbx_msg_present = 0;
        wait_eq("both_tx_phase", 0, 200);
        repeat (3) @(negedge clk);
        chk("both_drained", {bq.size(), tx_busy}, 0);

        // Read never completes: timeout.
        no_ready = 1; rd_base = 32'hC0;
        push_ev(2, 0);
        mbx_msg_present = 1;
        n = 0;
        while (!mbx_read && n < 10) begin @(negedge clk); n++; end
        chk("to_read_start", mbx_read, 1);
        n = 0;
        while (!err && n < 400) begin @(negedge clk); n++; end
        mbx_msg_present = 0;
        chk("to_cycles", n, TIMEOUT);
        chk("to_req_dropped", mbx_read, 0);
        no_ready = 0;
        repeat (5) @(negedge clk);
        chk("to_idle", {mbx_read, mbx_write, rx_valid, tx_busy}, 0);
        chk("to_rxdata_held", rx_data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});

        // Reset while word 2 of a TX is outstanding.
        lat = 2;
        push_w(6'h30, 32'hA1); push_w(6'h34, 32'hB2);
        tx_data = {32'hD4, 32'hC3, 32'hB2, 32'hA1}; tx_start = 1;
        @(negedge clk); tx_start = 0;
        n = 0;
        while (!(mbx_write && mbx_addr == 6'h38) && n < 100) begin @(negedge clk); n++; end
        chk("rst_mid_reached", {mbx_write, mbx_addr}, {1'b1, 6'h38});
        #2 reset = 1;
        #1 chk("rst_mid_async", {mbx_write, mbx_read, mbx_addr, mbx_wdata, tx_busy}, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (10) @(negedge clk);
        chk("rst_mid_idle", {tx_busy, mbx_write, mbx_read, rx_data}, 0);
        chk("rst_mid_queues", {bq.size(), eq.size()}, 0);

        // Peer acknowledge edges: 0->1->1->0->1 gives two pulses.
        lat = 0;
        push_ev(3, 0); push_ev(3, 0);
        mbx_msg_ack = 1; @(negedge clk);
        mbx_msg_ack = 1; @(negedge clk);
        mbx_msg_ack = 0; @(negedge clk);
        mbx_msg_ack = 1; @(negedge clk);
        repeat (4) @(negedge clk);
        mbx_msg_ack = 0;
        repeat (4) @(negedge clk);
        chk("ack_pulses", eq.size(), 0);

        chk("final_bus_queue", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
